// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the pipelined core. A shadow pipeline
// follows every instruction from EX (slot 0) through NUM_FWD forwarding slots
// (slot 1 = MEM, slot 2 = WB, ...). From this state it derives the EX operand
// forwarding selects and the ID-stage load-use stall.
//
// Parameters:
//   AW       register index width
//   NUM_FWD  number of forwarding source slots after EX
//   LD_READY first slot at which load data can be forwarded (1..NUM_FWD)
//   CNT_W    stall counter width
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   id_rs, id_rt      ID source registers, qualified by id_use_rs / id_use_rt
//   id_valid          ID holds a real instruction
//   id_dst, id_we     ID destination register and write enable
//   id_is_load        ID instruction is a load
//   flush_ex          squash the instruction entering EX
//   perf_clr          synchronous clear of stall_cnt
//   fwd_a, fwd_b      EX operand selects: 0 = regfile, k = slot k
//   stall_id          hold PC and IF/ID, insert a bubble into EX
//   stall_cnt         saturating count of stall cycles
//
// Build option:
//   FWD_HAZARD_PERF_EN  when defined, stall_cnt is a real saturating counter;
//                       otherwise stall_cnt is tied to 0 and perf_clr is
//                       ignored. Forwarding and stalling are identical in both.
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int AW       = 5,
    parameter int NUM_FWD  = 2,
    parameter int LD_READY = 2,
    parameter int CNT_W    = 16,
    localparam int SW      = $clog2(NUM_FWD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_dst,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush_ex,
    input  logic             perf_clr,
    output logic [SW-1:0]    fwd_a,
    output logic [SW-1:0]    fwd_b,
    output logic             stall_id,
    output logic [CNT_W-1:0] stall_cnt
);

    // EX-only source fields (slot 0)
    logic [AW-1:0] ex_rs_p0;
    logic [AW-1:0] ex_rt_p0;
    logic          ex_use_rs_p0;
    logic          ex_use_rt_p0;

    // Writer fields carried through every slot, 0 = EX
    logic [AW-1:0] slot_dst_p [0:NUM_FWD];
    logic          slot_we_p  [0:NUM_FWD];
    logic          slot_ld_p  [0:NUM_FWD];

    logic          ex_load;

    // A stalled or flushed ID instruction becomes a bubble in EX
    assign ex_load = id_valid && !stall_id && !flush_ex;

    // ---- ID -> EX -> forwarding slots: register indices ----
    // Indices are don't-care while the flags mark a bubble, so they need no
    // reset and load unconditionally.
    always_ff @(posedge clk) begin
        ex_rs_p0      <= id_rs;
        ex_rt_p0      <= id_rt;
        slot_dst_p[0] <= id_dst;
        for (int k = 1; k <= NUM_FWD; k++) begin
            slot_dst_p[k] <= slot_dst_p[k-1];
        end
    end

    // ---- ID -> EX -> forwarding slots: qualifying flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_use_rs_p0 <= 1'b0;
            ex_use_rt_p0 <= 1'b0;
            for (int k = 0; k <= NUM_FWD; k++) begin
                slot_we_p[k] <= 1'b0;
                slot_ld_p[k] <= 1'b0;
            end
        end else begin
            ex_use_rs_p0 <= ex_load && id_use_rs;
            ex_use_rt_p0 <= ex_load && id_use_rt;
            slot_we_p[0] <= ex_load && id_we;
            slot_ld_p[0] <= ex_load && id_is_load;
            for (int k = 1; k <= NUM_FWD; k++) begin
                slot_we_p[k] <= slot_we_p[k-1];
                slot_ld_p[k] <= slot_ld_p[k-1];
            end
        end
    end

    // ---- EX operand forwarding ----
    // Scan from the oldest slot down so the youngest matching producer is the
    // last assignment and wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = NUM_FWD; k >= 1; k--) begin
            if (slot_we_p[k] && (slot_dst_p[k] != '0)) begin
                if (ex_use_rs_p0 && (slot_dst_p[k] == ex_rs_p0)) begin
                    fwd_a = SW'(k);
                end
                if (ex_use_rt_p0 && (slot_dst_p[k] == ex_rt_p0)) begin
                    fwd_b = SW'(k);
                end
            end
        end
    end

    // ---- ID load-use stall ----
    // A load in slot j is too young if the consumer would reach EX before the
    // load reaches LD_READY. Only slots 0..LD_READY-2 can be too young; with
    // LD_READY = 1 the loop is empty and the stall never fires.
    logic ld_hit;

    always_comb begin
        ld_hit = 1'b0;
        for (int j = 0; j <= LD_READY - 2; j++) begin
            if (slot_ld_p[j] && slot_we_p[j] && (slot_dst_p[j] != '0)) begin
                if ((id_use_rs && (slot_dst_p[j] == id_rs)) ||
                    (id_use_rt && (slot_dst_p[j] == id_rt))) begin
                    ld_hit = 1'b1;
                end
            end
        end
    end

    assign stall_id = id_valid && ld_hit;

    // ---- stall counter ----
`ifdef FWD_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (perf_clr) begin
            stall_cnt_q <= '0;
        end else if (stall_id) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic perf_clr_unused;

    assign perf_clr_unused = perf_clr;
    assign stall_cnt       = '0;
`endif

endmodule
